// File: rtl/panel_pkg.sv
// Shared constants and state type for the front-panel key sequencer.
package panel_pkg;

    localparam int NKEYS_DEFAULT = 6;

    localparam int KEY_START    = 0;
    localparam int KEY_LOAD_ADD = 1;
    localparam int KEY_DEP      = 2;
    localparam int KEY_EXAM     = 3;
    localparam int KEY_CONT     = 4;
    localparam int KEY_STOP     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HELD = 2'd2,
        GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/panel_keys.sv
// Front-panel key sequencer: one strobe per press, release holdoff, run interlock.
// Optional auto-repeat of DEP/EXAM when PANEL_KEY_REPEAT_EN is defined.
module panel_keys
    import panel_pkg::*;
#(
    parameter int NKEYS         = NKEYS_DEFAULT,
    parameter int HOLDOFF       = 1000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys_in,
    input  logic             run,
    output logic [NKEYS-1:0] key_strobe,
    output logic             busy
);

    localparam int CMAX = (HOLDOFF > REPEAT_DELAY) ? HOLDOFF : REPEAT_DELAY;
    // One spare code above CMAX so the saturated value never equals a compare point.
    localparam int CW   = $clog2(CMAX + 2);
    localparam int SW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    localparam logic [CW-1:0]    CNT_MAX   = '1;
    localparam logic [CW-1:0]    HOLD_END  = CW'(HOLDOFF - 1);
    localparam logic [NKEYS-1:0] STOP_MASK = NKEYS'(1) << KEY_STOP;

    state_e            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [CW-1:0]     hold_q, hold_d, hold_inc;
    logic [NKEYS-1:0]  strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic [NKEYS-1:0]  eligible;
    logic [SW-1:0]     low_idx;
    logic              rpt_fire;

    assign eligible = run ? (keys_in & STOP_MASK) : keys_in;
    assign hold_inc = (hold_q == CNT_MAX) ? hold_q : hold_q + CW'(1);

    always_comb begin
        low_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (eligible[i]) low_idx = SW'(i);
        end
    end

`ifdef PANEL_KEY_REPEAT_EN
    localparam logic [CW-1:0] RPT_FIRST  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CW-1:0]    rpt_q, rpt_d, rpt_inc;
    logic [NKEYS-1:0] sel_mask;
    logic             rpt_key;

    assign sel_mask = NKEYS'(1) << sel_q;
    assign rpt_key  = (sel_q == SW'(KEY_DEP)) || (sel_q == SW'(KEY_EXAM));
    assign rpt_inc  = (rpt_q == CNT_MAX) ? rpt_q : rpt_q + CW'(1);

    // rpt_q tracks cycles since FIRE; parking it at CNT_MAX disarms repeats for the rest of the hold.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (state_q == FIRE) begin
            rpt_d = CW'(1);
        end else if (state_q == HELD) begin
            if (run || !rpt_key || ((keys_in & sel_mask) == '0)) begin
                rpt_d = CNT_MAX;
            end else if (rpt_inc == RPT_FIRST) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_RELOAD;
            end else begin
                rpt_d = rpt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HELD;
            sel_q    <= '0;
            hold_q   <= '0;
            strobe_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    state_d = FIRE;
                    sel_d   = low_idx;
                end
            end
            FIRE: state_d = HELD;
            HELD: begin
                if (keys_in == '0) begin
                    state_d = GAP;
                    hold_d  = '0;
                end
            end
            GAP: begin
                if (keys_in != '0) begin
                    state_d = HELD;
                end else begin
                    hold_d = hold_inc;
                    if (hold_inc >= HOLD_END) state_d = IDLE;
                end
            end
            default: state_d = HELD;
        endcase
    end

    // Outputs are registered, so decode from next state to land the strobe in the FIRE cycle.
    always_comb begin
        strobe_d = '0;
        if (state_d == FIRE) strobe_d = NKEYS'(1) << sel_d;
        else if (rpt_fire)   strobe_d = NKEYS'(1) << sel_q;
        busy_d = (state_d != IDLE);
    end

    assign key_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_panel_keys.sv
// Self-checking bench for panel_keys (HOLDOFF=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_panel_keys;

    localparam int NK = 6;
    localparam int HO = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct {
        int          cyc;
        logic [NK-1:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys_in;
    logic          run;
    logic [NK-1:0] key_strobe;
    logic          busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    exp_t mon_e;

    panel_keys #(
        .NKEYS(NK), .HOLDOFF(HO), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .keys_in(keys_in), .run(run),
        .key_strobe(key_strobe), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every non-zero strobe must match the head of the queue at the expected cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL strobe_missing cyc=%0d expected=%b at cyc=%0d", cyc, mon_e.val, mon_e.cyc);
        end
        if (key_strobe !== '0) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected cyc=%0d got=%b expected=none", cyc, key_strobe);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.cyc != cyc || mon_e.val !== key_strobe) begin
                    failures++;
                    $display("FAIL strobe_value cyc=%0d got=%b expected=%b at cyc=%0d",
                             cyc, key_strobe, mon_e.val, mon_e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [NK-1:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sbq.push_back(e);
    endtask

    // Expected auto-repeats for a key pressed at cycle c and held for h sampled cycles.
    task automatic push_repeats(input int c, input int h, input logic [NK-1:0] v);
`ifdef PANEL_KEY_REPEAT_EN
        for (int t = RD; t <= h - 1; t += RP) push(c + 1 + t, v);
`else
        if (h < 0) push(c, v);
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; keys_in = '0; run = 1'b0;
        tick(3);
        checks++;
        if (key_strobe !== '0) begin
            failures++; $display("FAIL reset_strobe got=%b expected=0", key_strobe);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b expected=1", busy);
        end
        rst = 1'b0;
        tick(HO - 1);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL reset_holdoff_busy got=%b expected=1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy got=%b expected=0", busy);
        end
    endtask

    task automatic test_single;
        int c;
        c = cyc;
        keys_in = 6'b000100;
        push(c + 1, 6'b000100);
        push_repeats(c, 20, 6'b000100);
        tick(2);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL single_busy got=%b expected=1", busy);
        end
        tick(18);
        keys_in = '0;
        tick(HO + 2);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL single_pending got=%0d expected=0", sbq.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL single_idle got=%b expected=0", busy);
        end
    endtask

    task automatic test_simultaneous;
        int c;
        c = cyc;
        keys_in = 6'b101000;
        push(c + 1, 6'b001000);
        tick(5);
        keys_in = 6'b100000;
        tick(15);
        keys_in = '0;
        tick(HO + 2);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL simul_pending got=%0d expected=0", sbq.size());
        end
    endtask

    task automatic test_run_interlock;
        int c;
        run = 1'b1;
        keys_in = 6'b000001;
        tick(5);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL run_start_busy got=%b expected=0", busy);
        end
        keys_in = '0;
        tick(1);
        c = cyc;
        keys_in = 6'b100000;
        push(c + 1, 6'b100000);
        tick(3);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL run_stop_busy got=%b expected=1", busy);
        end
        keys_in = '0;
        tick(HO + 2);
        run = 1'b0;
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL run_pending got=%0d expected=0", sbq.size());
        end
    endtask

    task automatic test_holdoff;
        int c;
        c = cyc;
        keys_in = 6'b000001;
        push(c + 1, 6'b000001);
        tick(3);
        keys_in = '0;
        tick(2);
        keys_in = 6'b000001;
        tick(3);
        keys_in = '0;
        tick(HO - 1);
        keys_in = 6'b000001;
        tick(3);
        keys_in = '0;
        tick(HO);
        c = cyc;
        keys_in = 6'b000001;
        push(c + 1, 6'b000001);
        tick(3);
        keys_in = '0;
        tick(HO + 2);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL holdoff_pending got=%0d expected=0", sbq.size());
        end
    endtask

    task automatic test_reset_mid_hold;
        int c;
        c = cyc;
        keys_in = 6'b000100;
        push(c + 1, 6'b000100);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (key_strobe !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rsthold_state got=%b/%b expected=000000/1", key_strobe, busy);
        end
        tick(8);
        keys_in = '0;
        tick(HO);
        c = cyc;
        keys_in = 6'b000100;
        push(c + 1, 6'b000100);
        tick(3);
        keys_in = '0;
        tick(HO + 2);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL rsthold_pending got=%0d expected=0", sbq.size());
        end
    endtask

    task automatic test_repeat;
        int c;
        c = cyc;
        keys_in = 6'b001000;
        push(c + 1, 6'b001000);
        push_repeats(c, 20, 6'b001000);
        tick(20);
        keys_in = '0;
        tick(HO + 2);
        // run rising mid-sequence cancels the repeats still to come
        c = cyc;
        keys_in = 6'b000100;
        push(c + 1, 6'b000100);
        push_repeats(c, 12, 6'b000100);
        tick(12);
        run = 1'b1;
        tick(8);
        keys_in = '0;
        tick(HO + 2);
        run = 1'b0;
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL repeat_pending got=%0d expected=0", sbq.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL repeat_idle got=%b expected=0", busy);
        end
    endtask

    initial begin
        rst = 1'b1; keys_in = '0; run = 1'b0;
        test_reset;
        test_single;
        test_simultaneous;
        test_run_interlock;
        test_holdoff;
        test_reset_mid_hold;
        test_repeat;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/panel_keys.md
PANEL_KEYS -- requirements
Module: panel_keys

Interface
REQ-001 Parameter NKEYS, default 6, number of momentary front-panel keys.
REQ-002 Parameter HOLDOFF, default 1000, minimum all-released cycles before a new key is accepted.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles before the first auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeats.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 keys_in  input  NKEYS  debounced key levels (1 = pressed); bit order 0 START, 1 LOAD_ADD, 2 DEP, 3 EXAM, 4 CONT, 5 STOP.
REQ-008 run  input  1  processor running flag.
REQ-009 key_strobe  output  NKEYS  registered, one-hot, single-cycle key command pulse.
REQ-010 busy  output  1  registered; high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, FIRE, HELD and GAP.
REQ-012 In IDLE, if the eligible set (keys_in masked per REQ-013) is non-zero, the FSM SHALL latch the lowest-index set bit into sel and go to FIRE.
REQ-013 While run=1, only STOP SHALL be eligible; other keys leave IDLE unchanged and never strobe.
REQ-014 FIRE SHALL last one cycle, drive key_strobe = one-hot(sel), and then enter HELD; strobe latency SHALL be 1 cycle after keys_in is sampled non-zero in IDLE.
REQ-015 In HELD, the FSM SHALL stay while keys_in != 0; extra keys pressed during HELD SHALL be ignored, including after sel is released.
REQ-016 HELD SHALL go to GAP on the first cycle keys_in == 0, clearing the holdoff counter.
REQ-017 GAP SHALL count the consecutive cycles with keys_in == 0 and enter IDLE when the count reaches HOLDOFF-1.
REQ-018 In GAP, any non-zero keys_in SHALL return the FSM to HELD without a strobe.
REQ-019 key_strobe SHALL be zero in every cycle except FIRE and the repeat cycles of REQ-024.
REQ-020 At most one key_strobe bit SHALL ever be high.
REQ-021 Counters SHALL be wide enough to hold max(HOLDOFF, REPEAT_DELAY) and SHALL saturate, never wrap.

Reset
REQ-022 rst SHALL take priority over all other inputs: key_strobe=0, busy=1, counters=0, sel=0, state=HELD.
REQ-023 Reset entering HELD guarantees that a key held through reset produces no strobe until all keys are released and HOLDOFF has elapsed.

Configuration
REQ-024 With PANEL_KEY_REPEAT_EN defined, in HELD with sel in {DEP, EXAM} and run=0, the block SHALL emit a one-cycle key_strobe = one-hot(sel) after REPEAT_DELAY held cycles and then every REPEAT_PERIOD cycles until release.
REQ-025 Without PANEL_KEY_REPEAT_EN, the repeat counter logic SHALL be absent and each press SHALL yield exactly one strobe.
REQ-026 If run rises during a repeat sequence, repeats SHALL stop immediately; HELD/GAP behaviour is otherwise unchanged.

Structure
REQ-027 Package panel_pkg SHALL hold the key index constants (KEY_START..KEY_STOP), NKEYS_DEFAULT and the state enum type.
REQ-028 No sub-module SHALL be used; the priority select, FSM and counters are implemented inline.

Verification (HOLDOFF=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Single press: keys_in=6'b000100 for 20 cycles in IDLE, run=0 -> exactly one key_strobe=6'b000100, one cycle after the press is sampled.
REQ-030 Simultaneous press: keys_in=6'b101000 -> strobe 6'b001000 only; releasing bit 3 while bit 5 is held -> no further strobe.
REQ-031 Run interlock: run=1, press START -> no strobe, busy=0; press STOP -> strobe 6'b100000.
REQ-032 Holdoff: release for 2 cycles, then press again -> no strobe; release for 4 cycles, then press -> one strobe.
REQ-033 Reset mid-hold: DEP held, assert rst for 1 cycle, keep DEP held -> no strobe until release plus 4 cycles and a new press.
REQ-034 Repeat, macro defined: EXAM held for 20 cycles -> strobes at FIRE, FIRE+10, FIRE+13, FIRE+16 and FIRE+19; macro undefined -> FIRE strobe only.
